// File: rtl/mux_3to1.sv
// Three-way data selector with a zero-latency combinational output and a
// one-stage registered copy carrying valid and illegal-select flags.
module mux_3to1 #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] ILLEGAL_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [1:0]       s,
  input  logic             in_valid,
  output logic [WIDTH-1:0] o,
  output logic [WIDTH-1:0] o_q,
  output logic             o_valid,
  output logic             sel_err,
  output logic             sel_err_sticky
);

  logic [WIDTH-1:0] w_sel;
  logic             w_illegal;

  logic [WIDTH-1:0] r_o_q;
  logic             r_o_valid;
  logic             r_sel_err;
  logic             r_sel_err_sticky;

  // Default arm makes an unknown select propagate X in simulation and keeps
  // synthesis from inferring a latch.
  always_comb begin
    w_sel = 'x;
    case (s)
      2'b00:   w_sel = a;
      2'b01:   w_sel = b;
      2'b10:   w_sel = c;
      2'b11:   w_sel = ILLEGAL_VAL;
      default: w_sel = 'x;
    endcase
  end

  assign w_illegal = (s == 2'b11);
  assign o         = w_sel;

  // Valid-only interface: in_valid qualifies a/b/c/s on a rising edge and
  // is always accepted (no ready/backpressure); o_valid marks o_q as holding
  // the value captured on the previous edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_o_q            <= '0;
      r_o_valid        <= 1'b0;
      r_sel_err        <= 1'b0;
      r_sel_err_sticky <= 1'b0;
    end else if (in_valid) begin
      r_o_q            <= w_sel;
      r_o_valid        <= 1'b1;
      r_sel_err        <= w_illegal;
      r_sel_err_sticky <= r_sel_err_sticky | w_illegal;
    end else begin
      r_o_valid        <= 1'b0;
      r_sel_err        <= 1'b0;
    end
  end

  assign o_q            = r_o_q;
  assign o_valid        = r_o_valid;
  assign sel_err        = r_sel_err;
  assign sel_err_sticky = r_sel_err_sticky;

endmodule

// File: tb/tb_mux_3to1.sv
// Directed bench for mux_3to1: a 1-bit instance for the hand-computed
// vectors and an 8-bit instance with a non-zero illegal value for random runs.
module tb_mux_3to1;

  logic       clk;
  logic       rst_n;

  // 1-bit instance
  logic       a, b, c, in_valid;
  logic [1:0] s;
  logic       o, o_q, o_valid, sel_err, sel_err_sticky;

  // 8-bit instance
  localparam logic [7:0] W_ILLEGAL = 8'hA5;
  logic [7:0] wa, wb, wc;
  logic [1:0] ws;
  logic       wv;
  logic [7:0] wo, wo_q;
  logic       wo_valid, wsel_err, wsel_err_sticky;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  logic       exp_err_q[$];

  mux_3to1 #(.WIDTH(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .s(s),
    .in_valid(in_valid), .o(o), .o_q(o_q), .o_valid(o_valid),
    .sel_err(sel_err), .sel_err_sticky(sel_err_sticky)
  );

  mux_3to1 #(.WIDTH(8), .ILLEGAL_VAL(W_ILLEGAL)) u_dut_w (
    .clk(clk), .rst_n(rst_n), .a(wa), .b(wb), .c(wc), .s(ws),
    .in_valid(wv), .o(wo), .o_q(wo_q), .o_valid(wo_valid),
    .sel_err(wsel_err), .sel_err_sticky(wsel_err_sticky)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                       input logic [7:0] mc, input logic [1:0] ms);
    case (ms)
      2'b00:   return ma;
      2'b01:   return mb;
      2'b10:   return mc;
      default: return W_ILLEGAL;
    endcase
  endfunction

  // driver: apply narrow inputs at the falling edge, check o 1 ns later
  task automatic drive(input logic da, input logic db, input logic dc,
                       input logic [1:0] ds, input logic dv,
                       input string tag, input logic exp_o);
    @(negedge clk);
    a = da; b = db; c = dc; s = ds; in_valid = dv;
    #1;
    check(tag, {7'b0, o}, {7'b0, exp_o});
  endtask

  // check registered outputs 1 ns after the next rising edge
  task automatic regs(input string tag, input logic e_q, input logic e_v,
                      input logic e_err, input logic e_sticky);
    @(posedge clk);
    #1;
    check({tag, ".o_q"},     {7'b0, o_q},            {7'b0, e_q});
    check({tag, ".o_valid"}, {7'b0, o_valid},        {7'b0, e_v});
    check({tag, ".sel_err"}, {7'b0, sel_err},        {7'b0, e_err});
    check({tag, ".sticky"},  {7'b0, sel_err_sticky}, {7'b0, e_sticky});
  endtask

  initial begin
    logic [7:0] exp_v;
    logic       exp_e;

    rst_n = 1'b1;
    a = 0; b = 0; c = 0; s = 2'b00; in_valid = 0;
    wa = 0; wb = 0; wc = 0; ws = 2'b00; wv = 0;
    #2 rst_n = 1'b0;
    #1;
    check("rst.o_q",     {7'b0, o_q},            8'h00);
    check("rst.o_valid", {7'b0, o_valid},        8'h00);
    check("rst.sel_err", {7'b0, sel_err},        8'h00);
    check("rst.sticky",  {7'b0, sel_err_sticky}, 8'h00);
    check("rst.o",       {7'b0, o},              8'h00);
    check("rst.wo_q",    wo_q,                   8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // basic selection
    drive(1, 0, 0, 2'b01, 1, "sel_b",   0);
    regs("cap_b", 0, 1, 0, 0);
    drive(1, 1, 0, 2'b10, 1, "sel_c",   0);
    regs("cap_c", 0, 1, 0, 0);
    drive(1, 0, 0, 2'b00, 1, "sel_a",   1);
    regs("cap_a", 1, 1, 0, 0);
    drive(0, 0, 1, 2'b01, 1, "sel_b0",  0);
    regs("cap_b0", 0, 1, 0, 0);
    drive(0, 0, 1, 2'b10, 1, "sel_c1",  1);
    regs("cap_c1", 1, 1, 0, 0);
    drive(0, 1, 0, 2'b00, 1, "sel_a0",  0);
    regs("cap_a0", 0, 1, 0, 0);

    // illegal select, then an idle cycle
    drive(1, 1, 1, 2'b11, 1, "sel_ill", 0);
    regs("cap_ill", 0, 1, 1, 1);
    drive(1, 1, 1, 2'b00, 0, "idle_o",  1);
    regs("idle", 0, 0, 0, 1);

    // capture a 1, then asynchronous reset between edges
    drive(1, 0, 0, 2'b00, 1, "pre_rst", 1);
    regs("pre_rst", 1, 1, 0, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst.o_q",     {7'b0, o_q},            8'h00);
    check("arst.o_valid", {7'b0, o_valid},        8'h00);
    check("arst.sel_err", {7'b0, sel_err},        8'h00);
    check("arst.sticky",  {7'b0, sel_err_sticky}, 8'h00);
    check("arst.o",       {7'b0, o},              8'h01);
    regs("in_rst", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 1, 2'b10, 1, "post_rst", 1);
    regs("post_rst", 1, 1, 0, 0);
    drive(0, 0, 0, 2'b00, 0, "narrow_idle", 0);

    // 8-bit instance: back-to-back random captures
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      wa = 8'($urandom_range(0, 255));
      wb = 8'($urandom_range(0, 255));
      wc = 8'($urandom_range(0, 255));
      ws = 2'($urandom_range(0, 3));
      wv = 1'b1;
      exp_v = model(wa, wb, wc, ws);
      exp_q.push_back(exp_v);
      exp_err_q.push_back(ws == 2'b11);
      #1;
      check("w.o", wo, exp_v);
      @(posedge clk);
      #1;
      exp_v = exp_q.pop_front();
      exp_e = exp_err_q.pop_front();
      check("w.o_q",     wo_q,              exp_v);
      check("w.o_valid", {7'b0, wo_valid},  8'h01);
      check("w.sel_err", {7'b0, wsel_err},  {7'b0, exp_e});
    end
    @(negedge clk);
    wa = 8'h3C; ws = 2'b11; wv = 1'b1;
    #1;
    check("w.illegal_o", wo, W_ILLEGAL);
    @(posedge clk);
    #1;
    check("w.illegal_q",  wo_q,                    W_ILLEGAL);
    check("w.illegal_st", {7'b0, wsel_err_sticky}, 8'h01);
    @(negedge clk);
    wv = 1'b0;
    @(posedge clk);
    #1;
    check("w.idle_valid", {7'b0, wo_valid}, 8'h00);
    check("w.idle_hold",  wo_q,             W_ILLEGAL);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
